key_event_classifier: RTL
=========================

KEY_EVENT_CLASSIFIER -- requirements
Module: key_event_classifier

Interface
REQ-001 Parameter LONG_CYC, default 24'd1_000_000: press duration in clk cycles that qualifies as a long press.
REQ-002 Parameter DBL_GAP_CYC, default 24'd250_000: maximum release gap in clk cycles between the two presses of a double click.
REQ-003 Parameter REPEAT_CYC, default 24'd200_000: auto-repeat period in clk cycles while held after a long press.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 key_level  input  1  debounced, clk-synchronous key level from the upstream debouncer; 0 = pressed, 1 = released.
REQ-007 single_click  output  1  one-cycle pulse, single click classified.
REQ-008 double_click  output  1  one-cycle pulse, double click classified.
REQ-009 long_press  output  1  one-cycle pulse, long press classified.
REQ-010 repeat_pulse  output  1  one-cycle pulse, auto-repeat while held.
REQ-011 led  output  4  user-visible value driven by classified events.

Function
REQ-012 Press edge = key_d==1 && key_level==0; release edge = key_d==0 && key_level==1; key_d = key_level delayed by one clk.
REQ-013 FSM states IDLE, PRESS1, WAIT2, PRESS2, HOLD; one 24-bit counter, cleared on every state change, incremented every cycle otherwise.
REQ-014 IDLE: press edge -> PRESS1; all else stay.
REQ-015 PRESS1: release edge with cnt < LONG_CYC-1 -> WAIT2; cnt == LONG_CYC-1 while pressed -> HOLD with long_press asserted next cycle; a release edge in the same cycle as cnt == LONG_CYC-1 is a long press.
REQ-016 WAIT2: press edge with cnt < DBL_GAP_CYC-1 -> PRESS2; cnt == DBL_GAP_CYC-1 -> IDLE with single_click asserted next cycle; a press edge in that same cycle is a double-click press.
REQ-017 PRESS2: release edge -> IDLE with double_click asserted next cycle, regardless of press duration; no long press from PRESS2.
REQ-018 HOLD: repeat_pulse asserted every REPEAT_CYC cycles while pressed, first pulse REPEAT_CYC cycles after long_press; release edge -> IDLE, no click event.
REQ-019 All pulse outputs registered, high exactly one cycle; at most one of the four pulses is high in any cycle.
REQ-020 led: single_click +1, double_click -1, long_press -> 4'b0000, repeat_pulse +1; increment and decrement wrap modulo 16 (4'b1111+1 = 0, 0-1 = 4'b1111); led updates in the same cycle its pulse is high.
REQ-021 Undefined state encoding -> IDLE next cycle, counter cleared, no pulse.

Reset
REQ-022 rst_n low: state IDLE, counter 0, all pulses 0, led 4'b0000, key_d 0.
REQ-023 key_d resetting to 0 means a key held pressed through reset release produces no event until released and pressed again.
REQ-024 Reset asserted mid-classification discards the pending event; no pulse is emitted for it after reset release.

Structure
REQ-025 FSM state encodings and the 24-bit counter width SHALL live in shared package key_pkg, also used by the upstream debouncer.
REQ-026 The counter with clear and terminal-count compare SHALL be sub-module key_timer (inputs clr, terminal value; output hit).

Verification (LONG_CYC=8, DBL_GAP_CYC=6, REPEAT_CYC=4)
REQ-027 Press 3 cycles, release, idle 10 -> single_click once, 6 cycles after the release edge; led 0->1.
REQ-028 Press 3, release 2, press 3, release -> double_click once after the second release, no single_click; led 1->0.
REQ-029 Hold 20 cycles from led=5 -> long_press 8 cycles after the press edge, led=0; repeat_pulse at +4 and +8 after that, led=2; release -> no further pulses.
REQ-030 led=15 then single click -> led=0; led=0 then double click -> led=15.
REQ-031 Reset during WAIT2, key held low across reset release -> no pulses and led=0 until release and a new press.
REQ-032 Release gap exactly 6 cycles -> single_click; the following press starts a fresh PRESS1.

Source files
------------

// File: rtl/key_pkg.sv
// =====================================================================
// key_pkg : shared key-handling state encodings and counter width
// Rev 1.0
// =====================================================================
`default_nettype none

package key_pkg;

   localparam int c_CNT_W = 24;

   typedef logic [c_CNT_W-1:0] cnt_t;

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_PRESS1 = 3'd1;
   localparam logic [2:0] c_ST_WAIT2  = 3'd2;
   localparam logic [2:0] c_ST_PRESS2 = 3'd3;
   localparam logic [2:0] c_ST_HOLD   = 3'd4;

   // A duration of N cycles completes when the free-running count reads N-1.
   function automatic cnt_t term_of(input cnt_t cyc);
      return cyc - cnt_t'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_timer.sv
// =====================================================================
// key_timer : 24-bit up-counter with synchronous clear and terminal hit
// Rev 1.0
// =====================================================================
`default_nettype none

module key_timer
   import key_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [c_CNT_W-1:0] term,
   output logic             hit
);

   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (clr)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + cnt_t'(1);
   end

   assign hit = (r_cnt == term);

endmodule

`default_nettype wire

// File: rtl/key_event_classifier.sv
// =====================================================================
// key_event_classifier : single / double / long-press / auto-repeat decoder
// Rev 1.0
// =====================================================================
`default_nettype none

module key_event_classifier
   import key_pkg::*;
#(
   parameter logic [c_CNT_W-1:0] LONG_CYC    = 24'd1_000_000,
   parameter logic [c_CNT_W-1:0] DBL_GAP_CYC = 24'd250_000,
   parameter logic [c_CNT_W-1:0] REPEAT_CYC  = 24'd200_000
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_level,
   output logic       single_click,
   output logic       double_click,
   output logic       long_press,
   output logic       repeat_pulse,
   output logic [3:0] led
);

   logic               r_key_d;
   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic               w_press;
   logic               w_release;
   logic               w_hit;
   logic               w_clr;
   logic [c_CNT_W-1:0] w_term;
   logic               w_single;
   logic               w_double;
   logic               w_long;
   logic               w_repeat;

   assign w_press   =  r_key_d & ~key_level;
   assign w_release = ~r_key_d &  key_level;

   always_comb begin
      case (r_state)
         c_ST_WAIT2: w_term = term_of(DBL_GAP_CYC);
         c_ST_HOLD:  w_term = term_of(REPEAT_CYC);
         default:    w_term = term_of(LONG_CYC);
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_single    = 1'b0;
      w_double    = 1'b0;
      w_long      = 1'b0;
      w_repeat    = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            if (w_press)
               w_state_nxt = c_ST_PRESS1;
         end
         c_ST_PRESS1: begin
            // Reaching the long-press threshold wins over a coincident release.
            if (w_hit) begin
               w_long      = 1'b1;
               w_state_nxt = w_release ? c_ST_IDLE : c_ST_HOLD;
            end else if (w_release) begin
               w_state_nxt = c_ST_WAIT2;
            end
         end
         c_ST_WAIT2: begin
            if (w_press) begin
               w_state_nxt = c_ST_PRESS2;
            end else if (w_hit) begin
               w_single    = 1'b1;
               w_state_nxt = c_ST_IDLE;
            end
         end
         c_ST_PRESS2: begin
            if (w_release) begin
               w_double    = 1'b1;
               w_state_nxt = c_ST_IDLE;
            end
         end
         c_ST_HOLD: begin
            if (w_release)
               w_state_nxt = c_ST_IDLE;
            else if (w_hit)
               w_repeat = 1'b1;
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   // The repeat period restarts on each pulse while HOLD is retained.
   assign w_clr = (w_state_nxt != r_state) | w_repeat;

   key_timer u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr),
      .term  (w_term),
      .hit   (w_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_d      <= 1'b0;
         r_state      <= c_ST_IDLE;
         single_click <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
         repeat_pulse <= 1'b0;
         led          <= 4'b0000;
      end else begin
         r_key_d      <= key_level;
         r_state      <= w_state_nxt;
         single_click <= w_single;
         double_click <= w_double;
         long_press   <= w_long;
         repeat_pulse <= w_repeat;
         if (w_single | w_repeat)
            led <= led + 4'd1;
         else if (w_double)
            led <= led - 4'd1;
         else if (w_long)
            led <= 4'b0000;
      end
   end

endmodule

`default_nettype wire
